// File: rtl/addsub_pkg.sv
// Shared types and helpers for the add/subtract datapath and its accumulator.
// Holds the FSM state enum, signed-limit constants and the signed-overflow rule.
package addsub_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    function automatic logic [MAX_W-1:0] signed_max(input int n);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < n - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [MAX_W-1:0] signed_min(input int n);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == n - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Overflow from the operand and result sign bits only, so it works at any width.
    function automatic logic addsub_ovf(input logic sub, input logic a_sign,
                                        input logic b_sign, input logic r_sign);
        if (sub) return (a_sign != b_sign) && (r_sign != a_sign);
        else     return (a_sign == b_sign) && (r_sign != a_sign);
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational N-bit two's-complement add/subtract with signed-overflow detect.
module addsub_core
    import addsub_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         ovf
);

    assign sum = sub ? (a - b) : (a + b);
    assign ovf = addsub_ovf(sub, a[N-1], b[N-1], sum[N-1]);

endmodule

// File: rtl/addsub_accumulator.sv
// Burst accumulator: folds BURST signed operands into one sum with a sticky overflow flag.
// Define ADDSUB_ACC_SATURATE_EN to clamp to the signed limits instead of wrapping.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int N     = 8,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] acc_out,
    output logic         overflow,
    output logic         fsm_state
);

    // Handshake: a beat moves only in a cycle where valid && ready are both high;
    // in_ready and out_valid depend on state alone, never on the partner's signal.

    localparam int CW = $clog2(BURST + 1);
    localparam logic [CW-1:0] LAST = CW'(BURST - 1);

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  acc;
    logic [N-1:0]  sum;
    logic [N-1:0]  acc_load;
    logic [CW-1:0] count;
    logic          ovf_flag;
    logic          step_ovf;
    logic          in_xfer;
    logic          out_xfer;

    addsub_core #(.N(N)) u_core (
        .a   (acc),
        .b   (in_data),
        .sub (in_sub),
        .sum (sum),
        .ovf (step_ovf)
    );

    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign acc_out   = acc;
    assign overflow  = ovf_flag;
    assign fsm_state = logic'(state);

`ifdef ADDSUB_ACC_SATURATE_EN
    localparam logic [MAX_W-1:0] SMAX_W  = signed_max(N);
    localparam logic [MAX_W-1:0] SMIN_W  = signed_min(N);
    localparam logic [N-1:0]     SAT_MAX = SMAX_W[N-1:0];
    localparam logic [N-1:0]     SAT_MIN = SMIN_W[N-1:0];

    // Overflow can only push away from the sign of acc, so acc's sign picks the limit.
    always_comb begin
        acc_load = sum;
        if (step_ovf) acc_load = acc[N-1] ? SAT_MIN : SAT_MAX;
    end
`else
    always_comb begin
        acc_load = sum;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACC;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ACC;
        end else begin
            case (state)
                ACC:     if (in_xfer && count == LAST) state_next = OUT;
                OUT:     if (out_xfer) state_next = ACC;
                default: state_next = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            count    <= '0;
            ovf_flag <= 1'b0;
        end else if (clear || out_xfer) begin
            acc      <= '0;
            count    <= '0;
            ovf_flag <= 1'b0;
        end else if (in_xfer) begin
            acc      <= acc_load;
            count    <= count + CW'(1);
            ovf_flag <= ovf_flag | step_ovf;
        end
    end

endmodule

// File: doc/addsub_accumulator.md
# addsub_accumulator

Sequential accumulate stage placed directly downstream of the team's N-bit adder/subtractor. It accepts a stream of signed two's-complement operands through a valid/ready handshake, with a per-operand add/subtract select. It folds a fixed-length burst of operands into a running N-bit sum and presents the finished sum, plus a sticky signed-overflow flag, on a valid/ready output. It turns the combinational add/subtract datapath into a pipelined, back-pressurable reduction unit.

## Interface
- N, default 8: operand and accumulator width in bits, two's complement; minimum 2.
- BURST, default 4: operands accepted per result; minimum 1.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- clear  input  1  synchronous abort; discards the partial burst.
- in_valid  input  1  operand present.
- in_ready  output  1  block can take an operand this cycle.
- in_data  input  N  signed operand.
- in_sub  input  1  1 = acc − in_data; 0 = acc + in_data.
- out_valid  output  1  burst result available.
- out_ready  input  1  consumer takes the result.
- acc_out  output  N  accumulated sum.
- overflow  output  1  sticky: signed overflow occurred during this burst.

## Operation
- States:
  - ACC: in_ready=1, out_valid=0.
  - OUT: in_ready=0, out_valid=1.
- Transfer rule: an operand transfers when in_valid && in_ready. A result transfers when out_valid && out_ready.
- On each operand transfer in ACC:
  - acc ← acc ± in_data, computed modulo 2^N.
  - count ← count+1.
  - overflow ← overflow | ovf.
- Overflow term ovf:
  - Add: sign(acc)==sign(in_data) and sign(result)≠sign(acc).
  - Subtract: sign(acc)≠sign(in_data) and sign(result)≠sign(acc).
- ACC→OUT: on the transfer that brings count to BURST. count uses ceil(log2(BURST+1)) bits.
- OUT→ACC: on result transfer. acc, count and overflow clear to 0 on the same edge.
- In OUT, acc_out and overflow hold stable until the result transfers. in_data and in_valid are ignored.
- clear:
  - Highest-priority synchronous event in either state.
  - Next edge: acc=0, count=0, overflow=0, state=ACC.
  - An operand or result presented in the same cycle is dropped.
- acc_out is driven by the acc register in both states (no combinational path from in_data).
- Hand-off happens only at burst end; a partial burst is never output.

## Timing
- Reset (rst_n=0, asynchronous) takes effect immediately, including mid-burst or while in OUT:
  - state=ACC, acc=0, count=0, overflow=0.
  - Outputs: in_ready=1, out_valid=0, acc_out=0, overflow=0.
- Throughput: one operand per cycle in ACC.
- Latency: out_valid rises on the edge that accepts operand BURST, i.e. 1 cycle after that operand is presented.
- Minimum burst period: BURST+1 cycles with out_ready held 1. There is a single OUT cycle, and in_ready=0 during it.
- Back-pressure: out_ready=0 holds OUT indefinitely, with acc_out and overflow stable.
- in_valid may drop at any time in ACC. count and acc hold.

## Configuration
- ADDSUB_ACC_SATURATE_EN defined:
  - When ovf=1, acc loads the signed limit instead of the wrapped sum: 2^(N−1)−1 for positive overflow, −2^(N−1) for negative.
  - The overflow flag behaves identically.
- Undefined: wrap-around modulo 2^N.

## Structure
- Shared package addsub_pkg holds:
  - state enum (ACC, OUT);
  - functions for signed max/min constants at a given N;
  - the ovf computation as a function, shared with the upstream adder/subtractor's bench.
- One sub-module, addsub_core: combinational N-bit add/subtract producing sum and ovf. The accumulator instantiates it with in_sub as the mode.
- Saturation muxing and the FSM stay in the top module.

## Test plan
- Reset/idle: hold rst_n=0, then release:
  - acc_out=0x00, overflow=0, in_ready=1, out_valid=0.
  - Assert rst_n=0 again after 2 operands: all return to 0 immediately.
- Mixed burst, N=8, BURST=4: +50, −100 (in_sub=1, in_data=100), +66, +0 on consecutive cycles:
  - out_valid=1 one cycle after the 4th operand.
  - acc_out=0x10, overflow=0.
- Overflow: +127, +1, +0, +0:
  - Wrap build: acc_out=0x80, overflow=1.
  - ADDSUB_ACC_SATURATE_EN build: acc_out=0x7F, overflow=1.
- Subtract of negative: in_sub=1 with in_data=0xFF, then in_sub=1 with in_data=0xC0, then +0, +0 → acc_out=0x41, overflow=0.
- Back-pressure: complete a burst with out_ready=0 for 5 cycles:
  - out_valid, acc_out and overflow stable; in_ready=0; operands presented during OUT are not counted.
  - Raise out_ready: next burst starts from acc=0.
- clear mid-burst: after 2 operands (+10, +20), assert clear together with in_valid (+5):
  - Next cycle acc_out=0 and count=0.
  - The following 4 operands of +1 produce acc_out=0x04.
